// File: rtl/qam_polyphase_fir.sv
// Multi-channel polyphase interpolating FIR for the QAM16 transmit path.
// One symbol in, L phases out, shared runtime-loadable coefficient bank.
module qam_polyphase_fir #(
  parameter int NCH = 2,
  parameter int DW  = 3,
  parameter int CW  = 12,
  parameter int L   = 4,
  parameter int K   = 4,
  parameter int OW  = 19,
  localparam int NT = L * K,
  localparam int AW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NCH*DW-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [1:0]          s_error,
  input  logic                s_bypass,
  output logic [NCH*OW-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [1:0]          m_error,
  input  logic                coef_we,
  input  logic [AW-1:0]       coef_addr,
  input  logic [CW-1:0]       coef_data,
  output logic [1:0]          dbg_state
);

  localparam int PW  = DW + CW;
  localparam int PHW = (L > 1) ? $clog2(L) : 1;

  if (OW < DW + CW + $clog2(K)) begin : g_ow_check
    $error("qam_polyphase_fir: OW too narrow for full-precision accumulation");
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // m_data/m_error hold while m_valid && !m_ready; s_ready depends only on
  // state and m_ready (never on s_valid).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1
  } state_t;

  state_t               state, state_nxt;
  logic [PHW-1:0]       p, p_nxt;
  logic signed [CW-1:0] h [NT];
  logic signed [DW-1:0] x [NCH][K];
  logic [1:0]           err_q;
  logic                 byp_q;

  logic                 adv;
  logic                 last;
  logic                 accept;
  logic                 load;
  logic [NCH*OW-1:0]    y;
  logic signed [PW-1:0] prod;
  logic signed [OW-1:0] acc;

  assign dbg_state = state;

  always_comb begin
    adv       = !m_valid || m_ready;
    last      = (p == PHW'(L - 1));
    s_ready   = adv && ((state == IDLE) || ((state == CALC) && last));
    accept    = s_valid && s_ready;
    load      = (state == CALC) && adv;
    state_nxt = state;
    p_nxt     = p;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = CALC;
          p_nxt     = '0;
        end
      end
      CALC: begin
        if (adv) begin
          if (!last) begin
            p_nxt = p + 1'b1;
          end else if (accept) begin
            p_nxt = '0;
          end else begin
            state_nxt = IDLE;
            p_nxt     = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        p_nxt     = '0;
      end
    endcase
  end

  // Phase p output from the current (pre-shift) delay lines and coefficients.
  always_comb begin
    y    = '0;
    prod = '0;
    acc  = '0;
    for (int c = 0; c < NCH; c++) begin
      acc = '0;
      for (int k = 0; k < K; k++) begin
        prod = h[AW'(k * L + int'(p))] * x[c][k];
        acc  = acc + OW'(prod);
      end
      if (byp_q) begin
        acc = OW'(x[c][0]);
      end
      y[c*OW +: OW] = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      p       <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_error <= '0;
      err_q   <= '0;
      byp_q   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < K; k++) begin
          x[c][k] <= '0;
        end
      end
      for (int n = 0; n < NT; n++) begin
        h[n] <= '0;
      end
      h[0] <= CW'(1);
    end else begin
      state <= state_nxt;
      p     <= p_nxt;
      // Writes land after this edge, so a phase computed now sees the old tap.
      if (coef_we && (int'(coef_addr) < NT)) begin
        h[coef_addr] <= coef_data;
      end
      if (accept) begin
        for (int c = 0; c < NCH; c++) begin
          for (int k = 1; k < K; k++) begin
            x[c][k] <= x[c][k-1];
          end
          x[c][0] <= s_data[c*DW +: DW];
        end
        err_q <= s_error;
        byp_q <= s_bypass;
      end
      if (load) begin
        m_data  <= y;
        m_valid <= 1'b1;
        m_error <= err_q;
      end else if ((state == IDLE) && m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
